// File: rtl/ex_div_stage.sv
// rtl/ex_div_stage.sv - EX stage: ALU, data-SRAM request, iterative 32-cycle divider
module ex_div_stage #(
  parameter int EX_TO_MEM_WD = 147,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [31:0]             id_pc,
  input  logic [2:0]              id_alu_op,
  input  logic [31:0]             id_src1,
  input  logic [31:0]             id_src2,
  input  logic [1:0]              id_div_op,
  input  logic [4:0]              id_mem_op,
  input  logic [1:0]              id_store,
  input  logic [31:0]             id_imm,
  input  logic                    id_rf_we,
  input  logic [4:0]              id_rf_waddr,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

  // Stage register contents
  logic [31:0] pc, src1, src2, imm;
  logic [2:0]  alu_op;
  logic [1:0]  div_op, store;
  logic [4:0]  mem_op, rf_waddr;
  logic        rf_we;

  // Only the EX and MEM stall bits matter here
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[STALL_WD-1:4], stall[1:0]};

  // Stage register: bubble when EX stops but MEM runs, capture when EX runs, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0; alu_op <= '0; src1 <= '0; src2 <= '0; div_op <= '0;
      mem_op <= '0; store <= '0; imm <= '0; rf_we <= 1'b0; rf_waddr <= '0;
    end else if (stall[2] && !stall[3]) begin
      pc <= '0; alu_op <= '0; src1 <= '0; src2 <= '0; div_op <= '0;
      mem_op <= '0; store <= '0; imm <= '0; rf_we <= 1'b0; rf_waddr <= '0;
    end else if (!stall[2]) begin
      pc <= id_pc; alu_op <= id_alu_op; src1 <= id_src1; src2 <= id_src2;
      div_op <= id_div_op; mem_op <= id_mem_op; store <= id_store;
      imm <= id_imm; rf_we <= id_rf_we; rf_waddr <= id_rf_waddr;
    end
  end

  // ALU
  logic [31:0] ex_result;
  always_comb begin
    ex_result = '0;
    case (alu_op)
      3'd0: ex_result = src1 + src2;
      3'd1: ex_result = src1 - src2;
      3'd2: ex_result = src1 & src2;
      3'd3: ex_result = src1 | src2;
      3'd4: ex_result = src1 ^ src2;
      3'd5: ex_result = {31'd0, $signed(src1) < $signed(src2)};
      3'd6: ex_result = {31'd0, src1 < src2};
      3'd7: ex_result = src2 << src1[4:0];
      default: ex_result = '0;
    endcase
  end

  // Data-SRAM request; misaligned halfword/word stores are silently dropped
  logic [31:0] addr;
  logic        misaligned;
  assign addr = src1 + imm;
  always_comb begin
    data_sram_wen   = 4'b0000;
    data_sram_wdata = '0;
    misaligned      = 1'b0;
    case (store)
      2'b01: begin
        data_sram_wen   = 4'b0001 << addr[1:0];
        data_sram_wdata = {4{src2[7:0]}};
      end
      2'b10: begin
        data_sram_wen   = addr[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{src2[15:0]}};
        misaligned      = addr[0];
      end
      2'b11: begin
        data_sram_wen   = 4'b1111;
        data_sram_wdata = src2;
        misaligned      = (addr[1:0] != 2'b00);
      end
      default: ;
    endcase
    if (misaligned) data_sram_wen = 4'b0000;
    data_sram_en = ((mem_op != 5'd0) || (store != 2'b00)) && !misaligned;
  end
  assign data_sram_addr = addr;

  // Divider operand decode
  logic        div_start, div_signed, div_by_zero;
  logic [31:0] mag1, mag2;
  assign div_signed  = (div_op == 2'b01);
  assign div_start   = (div_op == 2'b01) || (div_op == 2'b10);
  assign div_by_zero = (src2 == 32'd0);
  assign mag1 = (div_signed && src1[31]) ? -src1 : src1;
  assign mag2 = (div_signed && src2[31]) ? -src2 : src2;

  div_state_t  state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] rem_r, quo_r, dsr_r, hi_r, lo_r;
  logic        qneg, rneg;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  logic [32:0] shifted, diff;
  logic [31:0] step_rem, step_quo;
  always_comb begin
    shifted = {rem_r, quo_r[31]};
    diff    = shifted - {1'b0, dsr_r};
    if (!diff[32]) begin
      step_rem = diff[31:0];
      step_quo = {quo_r[30:0], 1'b1};
    end else begin
      step_rem = shifted[31:0];
      step_quo = {quo_r[30:0], 1'b0};
    end
  end

  // Divider state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Divider next-state and stall request
  always_comb begin
    state_nx        = state;
    stallreq_for_ex = 1'b0;
    case (state)
      S_IDLE: begin
        if (div_start) begin
          stallreq_for_ex = 1'b1;
          state_nx        = div_by_zero ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        stallreq_for_ex = 1'b1;
        if (cnt == 5'd31) state_nx = S_DONE;
      end
      S_DONE: begin
        if (!stall[2]) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Divider datapath; final result is sign-corrected as it is written to hi/lo
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; rem_r <= '0; quo_r <= '0; dsr_r <= '0;
      hi_r <= '0; lo_r <= '0; qneg <= 1'b0; rneg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_start) begin
            if (div_by_zero) begin
              lo_r <= 32'hFFFF_FFFF;
              hi_r <= src1;
            end else begin
              quo_r <= mag1;
              rem_r <= '0;
              dsr_r <= mag2;
              qneg  <= div_signed && (src1[31] ^ src2[31]);
              rneg  <= div_signed && src1[31];
              cnt   <= '0;
            end
          end
        end
        S_BUSY: begin
          rem_r <= step_rem;
          quo_r <= step_quo;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            lo_r <= qneg ? -step_quo : step_quo;
            hi_r <= rneg ? -step_rem : step_rem;
          end
        end
        default: ;
      endcase
    end
  end

  logic        div_done;
  logic [31:0] hi_out, lo_out;
  assign div_done = (state == S_DONE);
  assign hi_out   = div_done ? hi_r : 32'd0;
  assign lo_out   = div_done ? lo_r : 32'd0;

  assign ex_to_mem_bus = {div_done, div_done, hi_out, lo_out, mem_op, pc,
                          data_sram_en, data_sram_wen, (mem_op != 5'd0),
                          rf_we, rf_waddr, ex_result};

endmodule

// File: tb/tb_ex_div_stage.sv
// tb/tb_ex_div_stage.sv - scoreboard bench for ex_div_stage
module tb_ex_div_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [31:0]  id_pc, id_src1, id_src2, id_imm;
  logic [2:0]   id_alu_op;
  logic [1:0]   id_div_op, id_store;
  logic [4:0]   id_mem_op, id_rf_waddr;
  logic         id_rf_we;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic         stallreq_for_ex;
  logic [146:0] ex_to_mem_bus;

  ex_div_stage #(.EX_TO_MEM_WD(147), .STALL_WD(6)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .id_pc(id_pc), .id_alu_op(id_alu_op), .id_src1(id_src1), .id_src2(id_src2),
    .id_div_op(id_div_op), .id_mem_op(id_mem_op), .id_store(id_store),
    .id_imm(id_imm), .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .stallreq_for_ex(stallreq_for_ex), .ex_to_mem_bus(ex_to_mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, src1, src2, imm;
    logic [2:0]  alu;
    logic [1:0]  dv, st;
    logic [4:0]  mo, wa;
    logic        we;
  } in_t;

  typedef struct {
    logic [146:0] bus;
    logic         en;
    logic [3:0]   wen;
    logic [31:0]  addr, wdata;
    bit           chk_wdata;
    int           sc;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [146:0] got, input logic [146:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic in_t ins(logic [31:0] pc, logic [2:0] alu, logic [31:0] s1, logic [31:0] s2,
                              logic [1:0] dv, logic [4:0] mo, logic [1:0] st, logic [31:0] imm,
                              logic we, logic [4:0] wa);
    in_t i;
    i.pc = pc; i.alu = alu; i.src1 = s1; i.src2 = s2; i.dv = dv;
    i.mo = mo; i.st = st; i.imm = imm; i.we = we; i.wa = wa;
    return i;
  endfunction

  function automatic exp_t model(in_t i, logic hw, logic [31:0] hi, logic [31:0] lo, int sc);
    exp_t e;
    logic [31:0] res, addr, wdata;
    logic [3:0]  wen;
    logic        mis, en;
    case (i.alu)
      3'd0: res = i.src1 + i.src2;
      3'd1: res = i.src1 - i.src2;
      3'd2: res = i.src1 & i.src2;
      3'd3: res = i.src1 | i.src2;
      3'd4: res = i.src1 ^ i.src2;
      3'd5: res = ($signed(i.src1) < $signed(i.src2)) ? 32'd1 : 32'd0;
      3'd6: res = (i.src1 < i.src2) ? 32'd1 : 32'd0;
      default: res = i.src2 << i.src1[4:0];
    endcase
    addr  = i.src1 + i.imm;
    wen   = 4'b0000;
    wdata = 32'd0;
    case (i.st)
      2'b01: begin wen = 4'b0001 << addr[1:0]; wdata = {4{i.src2[7:0]}}; end
      2'b10: begin wen = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{i.src2[15:0]}}; end
      2'b11: begin wen = 4'b1111; wdata = i.src2; end
      default: ;
    endcase
    mis = (i.st == 2'b10 && addr[0]) || (i.st == 2'b11 && addr[1:0] != 2'b00);
    if (mis) wen = 4'b0000;
    en = (i.mo != 5'd0 || i.st != 2'b00) && !mis;
    e.bus = {hw, hw, hw ? hi : 32'd0, hw ? lo : 32'd0, i.mo, i.pc, en, wen,
             (i.mo != 5'd0), i.we, i.wa, res};
    e.en = en; e.wen = wen; e.addr = addr; e.wdata = wdata;
    e.chk_wdata = (i.st != 2'b00);
    e.sc = sc;
    return e;
  endfunction

  task automatic drive(input in_t i);
    id_pc = i.pc; id_alu_op = i.alu; id_src1 = i.src1; id_src2 = i.src2;
    id_div_op = i.dv; id_mem_op = i.mo; id_store = i.st; id_imm = i.imm;
    id_rf_we = i.we; id_rf_waddr = i.wa;
  endtask

  // Issue one instruction, act as the stall controller while EX asks for it,
  // then compare the stage outputs against the scoreboard head.
  task automatic send(input in_t i, input logic hw, input logic [31:0] hi,
                      input logic [31:0] lo, input int sc_exp);
    exp_t x;
    int   sc;
    bit   done;
    sb_q.push_back(model(i, hw, hi, lo, sc_exp));
    @(negedge clk);
    drive(i);
    stall = 6'b000000;
    @(posedge clk);
    #1;
    sc = 0;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (stallreq_for_ex) begin
        sc++;
        stall = 6'b001111;
      end else begin
        done = 1;
        stall = 6'b001100;
      end
    end
    check("timeout", done, 1'b1);
    x = sb_q.pop_front();
    check("bus", ex_to_mem_bus, x.bus);
    check("sram_en", data_sram_en, x.en);
    check("sram_wen", data_sram_wen, x.wen);
    check("sram_addr", data_sram_addr, x.addr);
    if (x.chk_wdata) check("sram_wdata", data_sram_wdata, x.wdata);
    check("stall_cycles", sc, sc_exp);
  endtask

  in_t a, b, c;
  logic [31:0] r1, r2;

  initial begin
    rst = 1'b1;
    stall = 6'b000000;
    drive(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_bus", ex_to_mem_bus, 147'd0);
    check("reset_stallreq", stallreq_for_ex, 1'b0);
    check("reset_en", data_sram_en, 1'b0);
    check("reset_wen", data_sram_wen, 4'd0);
    check("reset_addr", data_sram_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // add 5 + -1
    send(ins(32'h1000, 0, 5, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 3), 0, 0, 0, 0);
    check("add_result", ex_to_mem_bus[31:0], 32'd4);
    check("add_waddr", ex_to_mem_bus[36:32], 5'd3);
    check("add_hi_we", ex_to_mem_bus[146], 1'b0);

    // sb at 0x102, then misaligned sh at 0x101
    send(ins(32'h1004, 0, 32'h100, 32'hAB, 0, 0, 2'b01, 2, 0, 0), 0, 0, 0, 0);
    check("sb_wen", data_sram_wen, 4'b0100);
    check("sb_wdata", data_sram_wdata, 32'hABAB_ABAB);
    check("sb_addr", data_sram_addr, 32'h102);
    check("sb_en", data_sram_en, 1'b1);
    send(ins(32'h1008, 0, 32'h100, 32'h1234, 0, 0, 2'b10, 1, 0, 0), 0, 0, 0, 0);
    check("sh_mis_en", data_sram_en, 1'b0);
    check("sh_mis_wen", data_sram_wen, 4'd0);

    // aligned sh upper half, sw, misaligned sw, lw
    send(ins(32'h100C, 0, 32'h100, 32'h5678, 0, 0, 2'b10, 2, 0, 0), 0, 0, 0, 0);
    send(ins(32'h1010, 0, 32'h300, 32'hDEAD_BEEF, 0, 0, 2'b11, 0, 0, 0), 0, 0, 0, 0);
    send(ins(32'h1014, 0, 32'h300, 32'hDEAD_BEEF, 0, 0, 2'b11, 2, 0, 0), 0, 0, 0, 0);
    send(ins(32'h1018, 0, 32'h200, 0, 0, 5'b00001, 0, 4, 1, 7), 0, 0, 0, 0);

    // random ALU ops
    for (int k = 0; k < 8; k++)
      send(ins(32'h2000 + 4 * k, 3'($urandom_range(0, 7)), $urandom, $urandom,
               0, 0, 0, 0, 1, 5'($urandom_range(1, 31))), 0, 0, 0, 0);

    // divu 100 / 7
    send(ins(32'h3000, 0, 100, 7, 2'b10, 0, 0, 0, 0, 0), 1, 32'd2, 32'd14, 33);
    check("divu_lo", ex_to_mem_bus[112:81], 32'd14);
    check("divu_hi", ex_to_mem_bus[144:113], 32'd2);
    check("divu_we", ex_to_mem_bus[146:145], 2'b11);

    // signed division cases
    send(ins(32'h3004, 0, 32'hFFFF_FFF9, 2, 2'b01, 0, 0, 0, 0, 0), 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    send(ins(32'h3008, 0, 7, 32'hFFFF_FFFE, 2'b01, 0, 0, 0, 0, 0), 1, 32'd1, 32'hFFFF_FFFD, 33);
    send(ins(32'h300C, 0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 0, 0, 0, 0, 0), 1, 32'd0, 32'h8000_0000, 33);

    // divide by zero, and the reserved op which must not divide
    send(ins(32'h3010, 0, 9, 0, 2'b01, 0, 0, 0, 0, 0), 1, 32'd9, 32'hFFFF_FFFF, 1);
    send(ins(32'h3014, 0, 9, 0, 2'b10, 0, 0, 0, 0, 0), 1, 32'd9, 32'hFFFF_FFFF, 1);
    send(ins(32'h3018, 0, 9, 0, 2'b11, 0, 0, 0, 1, 2), 0, 0, 0, 0);

    // random unsigned divides
    for (int k = 0; k < 3; k++) begin
      r1 = $urandom;
      r2 = 32'($urandom_range(1, 1000));
      send(ins(32'h4000 + 4 * k, 0, r1, r2, 2'b10, 0, 0, 0, 0, 0), 1, r1 % r2, r1 / r2, 33);
    end

    // reset in the middle of a divu
    @(negedge clk);
    drive(ins(32'h5000, 0, 1000, 3, 2'b10, 0, 0, 0, 0, 0));
    stall = 6'b000000;
    @(posedge clk);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      stall = stallreq_for_ex ? 6'b001111 : 6'b001100;
    end
    check("mid_div_stallreq", stallreq_for_ex, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_stallreq", stallreq_for_ex, 1'b0);
    check("rst_bus", ex_to_mem_bus, 147'd0);
    @(negedge clk);
    drive(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    send(ins(32'h5004, 0, 32'h10, 32'h20, 0, 0, 0, 0, 1, 9), 0, 0, 0, 0);

    // bubble, then hold
    a = ins(32'h6000, 1, 50, 8, 0, 0, 0, 0, 1, 4);
    b = ins(32'h6004, 4, 32'hF0F0, 32'h0FF0, 0, 0, 0, 0, 1, 5);
    c = ins(32'h6008, 2, 32'hFFFF, 32'h1234, 0, 0, 0, 0, 1, 6);
    send(a, 0, 0, 0, 0);
    @(negedge clk);
    drive(b);
    stall = 6'b000100;
    @(posedge clk);
    #1;
    check("bubble_bus", ex_to_mem_bus, 147'd0);
    check("bubble_en", data_sram_en, 1'b0);
    send(b, 0, 0, 0, 0);
    @(negedge clk);
    drive(c);
    stall = 6'b001100;
    @(posedge clk);
    #1;
    check("hold_bus", ex_to_mem_bus, model(b, 0, 0, 0, 0).bus);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
